sw_debounce: RTL

Conditions the ten raw slide-switch inputs before they reach the switch PIO's in_port in the Nios display system. Each bit is:
- synchronised into the clk domain, then
- debounced with an independent stability counter.
The block presents a glitch-free switch vector plus a per-bit one-cycle change strobe, which the frequency-meter control logic can use without polling.

---
 rtl/sw_debounce.sv | 73 +++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit synchroniser followed by an independent
// stability-counter debouncer, with registered change and rise strobes.
module sw_debounce #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_change,
    output logic [WIDTH-1:0] sw_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [CNT_W-1:0]                  cnt_q [WIDTH];
    logic [CNT_W-1:0]                  cnt_d [WIDTH];
    logic [WIDTH-1:0]                  clean_d;
    logic [WIDTH-1:0]                  accept;

    assign sync = sync_q[SYNC_STAGES-1];

    // Plain flop chain; stage 0 captures the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Any cycle where the synchronised level matches the accepted one restarts the window.
    always_comb begin
        clean_d = sw_clean;
        accept  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == sw_clean[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                cnt_d[i]   = '0;
                clean_d[i] = sync[i];
                accept[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            sw_clean  <= '0;
            sw_change <= '0;
            sw_rise   <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_clean  <= clean_d;
            sw_change <= accept;
            sw_rise   <= accept & sync;
        end
    end

endmodule
